// File: rtl/pythag_mag_seq_pkg.sv
// pythag_pkg: shared types and width helpers for the pythag_mag_seq engine.
//   state_e        : FSM state encoding (ROUND is only reachable when the
//                    round-to-nearest feature is built in)
//   sum_w(W)       : width of x^2 + y^2            = 2W+1
//   res_w(W)       : width of the magnitude result = W+1
//   cnt_w(W)       : width of the bit-pair counter = $clog2(W+1)
package pythag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    ROOT,
    ROUND,
    DONE
  } state_e;

  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int res_w(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pythag_mag_seq_if.sv
// pythag_mag_seq_if: operand/result handshake bundle for pythag_mag_seq.
//   in_valid/in_ready/x_in/y_in : operand pair handshake (producer -> engine)
//   out_valid/out_ready/mag_out : result handshake (engine -> consumer)
//   busy                        : engine is not in IDLE
// Modports: slave = engine side, master = producer/consumer side.
interface pythag_mag_seq_if #(
  parameter int W = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   mag_out;
  logic         busy;

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, busy
  );

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, busy
  );

endinterface

// File: rtl/pythag_mag_seq_isqrt_step.sv
// pythag_isqrt_step: one combinational restoring square-root iteration.
//   rem_i  : partial remainder (RW+2 bits)
//   root_i : partial root      (RW bits)
//   pair_i : next two radicand bits, MSB first
//   rem_o  : updated remainder
//   root_o : updated root (one new bit shifted in at the LSB)
module pythag_isqrt_step #(
  parameter int RW = 9
) (
  input  logic [RW+1:0] rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [RW+1:0] rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+3:0] cand;
  logic [RW+3:0] trial_sub;
  logic          ge;

  always_comb begin
    cand      = {rem_i, pair_i};
    trial_sub = {1'b0, root_i, 2'b01};
    ge        = (cand >= trial_sub);
    // The remainder never exceeds 2*root, so truncating to RW+2 bits is exact.
    rem_o     = ge ? (RW+2)'(cand - trial_sub) : (RW+2)'(cand);
    root_o    = (RW)'({root_i, ge});
  end

endmodule

// File: rtl/pythag_mag_seq.sv
// pythag_mag_seq: iterative Euclidean magnitude, mag = isqrt(x^2 + y^2).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   ena   : global enable; low freezes every register
//   bus   : pythag_mag_seq_if.slave (operand and result handshakes, busy)
// Optional build macro ROUND_NEAREST_EN: adds a ROUND state so the result is
// rounded to nearest instead of floor(sqrt); latency grows by one cycle.
module pythag_mag_seq
  import pythag_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  pythag_mag_seq_if.slave         bus
);

  localparam int SW = sum_w(W);
  localparam int RW = res_w(W);
  localparam int CW = cnt_w(W);

  state_e         state_q;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [SW-1:0]  sum_q;
  logic [RW+1:0]  rem_q;
  logic [RW+1:0]  rem_d;
  logic [RW-1:0]  root_q;
  logic [RW-1:0]  root_d;
  logic [RW-1:0]  mag_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [1:0]     pair;

  // Radicand is zero-extended to an even width so the top pair is {0, sum[2W]}.
  assign pair = 2'({1'b0, sum_q} >> {cnt_q, 1'b0});

  pythag_isqrt_step #(.RW(RW)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pair_i (pair),
    .rem_o  (rem_d),
    .root_o (root_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.x_in;
            y_q        <= bus.y_in;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SQUARE;
          end
        end
        SQUARE: begin
          sum_q   <= SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= CW'(W);
          state_q <= ROOT;
        end
        ROOT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          if (cnt_q == '0) begin
`ifdef ROUND_NEAREST_EN
            state_q     <= ROUND;
`else
            mag_q       <= root_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef ROUND_NEAREST_EN
        ROUND: begin
          // sqrt(S) > root + 1/2  <=>  S - root^2 > root for integer S.
          mag_q       <= (rem_q > {2'b00, root_q}) ? root_q + RW'(1) : root_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mag_out   = mag_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pythag_mag_seq.sv
// Self-checking bench for pythag_mag_seq (W=8): directed vector table,
// backpressure, enable freeze, mid-computation reset and random pairs
// against an independent integer square-root model.
module tb_pythag_mag_seq;

  localparam int W = 8;
`ifdef ROUND_NEAREST_EN
  localparam int LAT = W + 3;
`else
  localparam int LAT = W + 2;
`endif

  logic clk;
  logic rst_n;
  logic ena;

  pythag_mag_seq_if #(.W(W)) bus ();

  pythag_mag_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           fl;
    int           rn;
  } vec_t;

  vec_t tv[12];

  function automatic int ref_mag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef ROUND_NEAREST_EN
    if (4 * s > (2 * r + 1) * (2 * r + 1)) r++;
`endif
    return r;
  endfunction

  // Issues one operand pair, keeps in_valid high with junk operands while the
  // engine is busy, optionally freezes ena mid-ROOT and holds off out_ready.
  task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit glitch, input int hold,
                         output int mag, output int lat);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_drop", int'(bus.in_ready), 0);
    bus.x_in = 8'hAA;
    bus.y_in = 8'h55;
    k = 0;
    lat = -1;
    mag = -1;
    while (k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (glitch && k == 3) ena = 1'b0;
      if (glitch && k == 8) ena = 1'b1;
      if (bus.out_valid) begin
        lat = k;
        mag = int'(bus.mag_out);
        break;
      end
    end
    if (lat < 0) begin
      chk("out_valid_timeout", 0, 1);
      ena = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_mag_stable", int'(bus.mag_out), mag);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rel_out_valid", int'(bus.out_valid), 0);
    chk("rel_in_ready", int'(bus.in_ready), 1);
    chk("rel_busy", int'(bus.busy), 0);
    chk("idle_mag_hold", int'(bus.mag_out), mag);
  endtask

  initial begin
    int mag;
    int lat;
    int exp;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    tv[0]  = '{x: 8'd3,   y: 8'd4,   fl: 5,   rn: 5};
    tv[1]  = '{x: 8'd5,   y: 8'd12,  fl: 13,  rn: 13};
    tv[2]  = '{x: 8'd7,   y: 8'd24,  fl: 25,  rn: 25};
    tv[3]  = '{x: 8'd6,   y: 8'd8,   fl: 10,  rn: 10};
    tv[4]  = '{x: 8'd0,   y: 8'd0,   fl: 0,   rn: 0};
    tv[5]  = '{x: 8'd1,   y: 8'd1,   fl: 1,   rn: 1};
    tv[6]  = '{x: 8'd2,   y: 8'd3,   fl: 3,   rn: 4};
    tv[7]  = '{x: 8'd255, y: 8'd255, fl: 360, rn: 361};
    tv[8]  = '{x: 8'd200, y: 8'd100, fl: 223, rn: 224};
    tv[9]  = '{x: 8'd255, y: 8'd0,   fl: 255, rn: 255};
    tv[10] = '{x: 8'd0,   y: 8'd1,   fl: 1,   rn: 1};
    tv[11] = '{x: 8'd10,  y: 8'd10,  fl: 14,  rn: 14};

    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_mag", int'(bus.mag_out), 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
`ifdef ROUND_NEAREST_EN
      exp = tv[i].rn;
`else
      exp = tv[i].fl;
`endif
      run_txn(tv[i].x, tv[i].y, 1'b0, (i == 1) ? 20 : 0, mag, lat);
      chk($sformatf("vec%0d_mag", i), mag, exp);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
    end

    // Enable freeze for 5 cycles inside ROOT stretches latency by 5.
    run_txn(8'd5, 8'd12, 1'b1, 0, mag, lat);
    chk("ena_freeze_mag", mag, 13);
    chk("ena_freeze_lat", lat, LAT + 5);

    // Reset mid-ROOT: outputs return to reset values without a clock edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = 8'd5;
    bus.y_in     = 8'd12;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_mag", int'(bus.mag_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'd3, 8'd4, 1'b0, 0, mag, lat);
    chk("post_rst_mag", mag, 5);
    chk("post_rst_lat", lat, LAT);

    for (int i = 0; i < 100; i++) begin
      rx = W'($urandom_range(0, (1 << W) - 1));
      ry = W'($urandom_range(0, (1 << W) - 1));
      run_txn(rx, ry, 1'b0, 0, mag, lat);
      chk($sformatf("rand%0d_mag(%0d,%0d)", i, rx, ry), mag, ref_mag(int'(rx), int'(ry)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
